// File: rtl/fmt_ctrl_pkg.sv
// Shared types and constants for the formatter response grant controller.
package fmt_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    GNT  = 2'd1,
    WAIT = 2'd2,
    RECV = 2'd3
  } state_e;

  localparam int unsigned ERR_NOSTART = 0;
  localparam int unsigned ERR_END     = 1;
  localparam int unsigned ERR_ZLEN    = 2;
  localparam int unsigned ERR_W       = 3;

  localparam int unsigned MAX_LEN  = 31;
  localparam int unsigned LEN_W    = 5;
  localparam int unsigned CHID_W   = 2;
  localparam int unsigned CREDIT_W = 6;

  // Per-word sideband stored next to the data word in the FIFO
  typedef struct packed {
    logic [CHID_W-1:0] chid;
    logic              last;
  } rsp_tag_t;

endpackage

// File: rtl/fmt_sync_fifo.sv
// First-word fall-through synchronous FIFO; pop is applied before push so a
// full FIFO can accept a word in the same cycle it releases one.
module fmt_sync_fifo #(
  parameter int unsigned W     = 35,
  parameter int unsigned DEPTH = 32,
  parameter int unsigned CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             push_i,
  input  logic [W-1:0]     wdata_i,
  input  logic             pop_i,
  output logic             valid_o,
  output logic [W-1:0]     rdata_o,
  output logic [CNT_W-1:0] count_o
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [W-1:0]     mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             do_pop;

  function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
    return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
  endfunction

  assign do_pop  = pop_i && (cnt_q != '0);
  assign valid_o = (cnt_q != '0);
  assign rdata_o = mem_q[rd_ptr_q];
  assign count_o = cnt_q;

  // Pointer and occupancy next-state
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push_i) wr_ptr_d = ptr_inc(wr_ptr_q);
    if (do_pop) rd_ptr_d = ptr_inc(rd_ptr_q);
    cnt_d = cnt_q + CNT_W'(push_i) - CNT_W'(do_pop);
  end

  // Pointer and occupancy registers
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  // Storage array, no reset needed
  always_ff @(posedge clk) begin
    if (push_i) mem_q[wr_ptr_q] <= wdata_i;
  end

  // Credit scheme must never push into a full FIFO without a same-cycle pop
  a_no_overflow: assert property (@(posedge clk) disable iff (!rstn)
    push_i |-> ((32'(cnt_q) < DEPTH) || do_pop));

endmodule

// File: rtl/fmt_rsp_grant_ctrl.sv
// Credit-based grant scheduler and burst acceptor for the formatter response bus.
module fmt_rsp_grant_ctrl
  import fmt_ctrl_pkg::*;
#(
  parameter int unsigned DEPTH = 32,
  parameter int unsigned DW    = 32
) (
  input  logic                clk,
  input  logic                rstn,
  input  logic                gnt_en,
  input  logic                fmt_req,
  input  logic [CHID_W-1:0]   fmt_chid,
  input  logic [LEN_W-1:0]    fmt_length,
  output logic                fmt_grant,
  input  logic                fmt_start,
  input  logic                fmt_end,
  input  logic [DW-1:0]       fmt_data,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [DW-1:0]       out_data,
  output logic [CHID_W-1:0]   out_chid,
  output logic                out_last,
  output logic [CREDIT_W-1:0] credit,
  output logic [ERR_W-1:0]    err,
  input  logic                err_clr
);

  localparam int unsigned TAG_W = $bits(rsp_tag_t);
  localparam int unsigned FW    = DW + TAG_W;
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  state_e              state_q, state_d;
  logic                grant_q, grant_d;
  logic [LEN_W-1:0]    len_q, len_d;
  logic [CHID_W-1:0]   chid_q, chid_d;
  logic [LEN_W-1:0]    cnt_q, cnt_d;
  logic [CREDIT_W-1:0] credit_q, credit_d;
  logic [ERR_W-1:0]    err_q, err_d;

  logic                word_c, push_c, push_last_c, pop_c, at_end_c;
  logic [CREDIT_W-1:0] reserve_c, release_c;
  logic [ERR_W-1:0]    err_set_c;
  logic [FW-1:0]       fifo_wdata, fifo_rdata;
  logic [CNT_W-1:0]    fifo_cnt;
  rsp_tag_t            rd_tag;

  assign pop_c    = out_valid & out_ready;
  assign at_end_c = (cnt_q == (len_q - LEN_W'(1)));

  // FSM next-state, burst word accounting and credit reserve/release amounts
  always_comb begin
    state_d     = state_q;
    grant_d     = 1'b0;
    len_d       = len_q;
    chid_d      = chid_q;
    cnt_d       = cnt_q;
    word_c      = 1'b0;
    push_c      = 1'b0;
    push_last_c = 1'b0;
    reserve_c   = '0;
    release_c   = '0;
    err_set_c   = '0;
    case (state_q)
      IDLE: begin
        if (fmt_req) begin
          if (fmt_length == '0) begin
            err_set_c[ERR_ZLEN] = 1'b1;
          end else if (gnt_en && (credit_q >= CREDIT_W'(fmt_length))) begin
            len_d     = fmt_length;
            chid_d    = fmt_chid;
            cnt_d     = '0;
            reserve_c = CREDIT_W'(fmt_length);
            grant_d   = 1'b1;
            state_d   = GNT;
          end
        end
      end
      GNT: state_d = WAIT;
      WAIT: begin
        if (fmt_start) begin
          word_c = 1'b1;
        end else begin
          err_set_c[ERR_NOSTART] = 1'b1;
          release_c              = CREDIT_W'(len_q);
          state_d                = IDLE;
        end
      end
      RECV: begin
        word_c = 1'b1;
        if (fmt_start) err_set_c[ERR_END] = 1'b1;
      end
      default: state_d = IDLE;
    endcase

    // An early end truncates the packet and returns the unused reservation
    if (word_c) begin
      push_c      = 1'b1;
      push_last_c = at_end_c | fmt_end;
      cnt_d       = cnt_q + LEN_W'(1);
      if (fmt_end && !at_end_c) begin
        err_set_c[ERR_END] = 1'b1;
        release_c          = CREDIT_W'(len_q - cnt_q - LEN_W'(1));
        state_d            = IDLE;
      end else if (!fmt_end && at_end_c) begin
        err_set_c[ERR_END] = 1'b1;
        state_d            = IDLE;
      end else if (at_end_c) begin
        state_d = IDLE;
      end else begin
        state_d = RECV;
      end
    end
  end

  // Credit and sticky error next-state; a new error beats a same-cycle clear
  always_comb begin
    credit_d = credit_q - reserve_c + release_c + CREDIT_W'(pop_c);
    err_d    = (err_q & ~{ERR_W{err_clr}}) | err_set_c;
  end

  // Control registers
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q  <= IDLE;
      grant_q  <= 1'b0;
      len_q    <= '0;
      chid_q   <= '0;
      cnt_q    <= '0;
      credit_q <= CREDIT_W'(DEPTH);
      err_q    <= '0;
    end else begin
      state_q  <= state_d;
      grant_q  <= grant_d;
      len_q    <= len_d;
      chid_q   <= chid_d;
      cnt_q    <= cnt_d;
      credit_q <= credit_d;
      err_q    <= err_d;
    end
  end

  assign fifo_wdata = {fmt_data, chid_q, push_last_c};

  fmt_sync_fifo #(
    .W     (FW),
    .DEPTH (DEPTH),
    .CNT_W (CNT_W)
  ) u_fifo (
    .clk     (clk),
    .rstn    (rstn),
    .push_i  (push_c),
    .wdata_i (fifo_wdata),
    .pop_i   (pop_c),
    .valid_o (out_valid),
    .rdata_o (fifo_rdata),
    .count_o (fifo_cnt)
  );

  assign {out_data, rd_tag} = fifo_rdata;
  assign out_chid  = rd_tag.chid;
  assign out_last  = rd_tag.last;
  assign fmt_grant = grant_q;
  assign credit    = credit_q;
  assign err       = err_q;

  // Free credit plus stored words can never exceed the buffer size
  a_credit_max: assert property (@(posedge clk) disable iff (!rstn)
    credit_q <= CREDIT_W'(DEPTH));
  a_credit_sum: assert property (@(posedge clk) disable iff (!rstn)
    (32'(fifo_cnt) + 32'(credit_q)) <= DEPTH);

endmodule

// File: tb/tb_fmt_rsp_grant_ctrl.sv
// Randomized bench for fmt_rsp_grant_ctrl against a queue-based reference model.
module tb_fmt_rsp_grant_ctrl;

  localparam int unsigned DEPTH = 32;
  localparam int unsigned DW    = 32;

  logic          clk, rstn, gnt_en, fmt_req, fmt_grant, fmt_start, fmt_end;
  logic          out_valid, out_ready, out_last, err_clr;
  logic [1:0]    fmt_chid, out_chid;
  logic [4:0]    fmt_length;
  logic [DW-1:0] fmt_data, out_data;
  logic [5:0]    credit;
  logic [2:0]    err;

  int n_vec = 0;
  int n_err = 0;

  // Reference model: words stored in the buffer, words promised but not yet
  // delivered, sticky error flags, expected grant pulse.
  logic [DW+2:0] exp_q[$];
  int            reserved;
  logic [2:0]    err_m;
  logic          grant_m;

  int   rdy_mode;       // 0: never ready, 1: random, 2: always ready
  int   rdy_zero_left;  // forced not-ready cycles before rdy_mode applies
  logic rand_gnt_en;
  int   credit_at_grant;

  fmt_rsp_grant_ctrl #(.DEPTH(DEPTH), .DW(DW)) dut (
    .clk        (clk),
    .rstn       (rstn),
    .gnt_en     (gnt_en),
    .fmt_req    (fmt_req),
    .fmt_chid   (fmt_chid),
    .fmt_length (fmt_length),
    .fmt_grant  (fmt_grant),
    .fmt_start  (fmt_start),
    .fmt_end    (fmt_end),
    .fmt_data   (fmt_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .out_chid   (out_chid),
    .out_last   (out_last),
    .credit     (credit),
    .err        (err),
    .err_clr    (err_clr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic int credit_model();
    return int'(DEPTH) - exp_q.size() - reserved;
  endfunction

  task automatic check_outputs();
    logic [DW+2:0] head;
    check_eq("grant", 64'(fmt_grant), 64'(grant_m));
    check_eq("out_valid", 64'(out_valid), 64'(exp_q.size() != 0));
    if (exp_q.size() != 0) begin
      head = exp_q[0];
      check_eq("out_data", 64'(out_data), 64'(head[DW+2:3]));
      check_eq("out_chid", 64'(out_chid), 64'(head[2:1]));
      check_eq("out_last", 64'(out_last), 64'(head[0]));
    end
    check_eq("credit", 64'(credit), 64'(credit_model()));
    check_eq("err", 64'(err), 64'(err_m));
  endtask

  // One clock: drive inputs, advance the model across the edge, check outputs.
  task automatic cycle(input logic req, input logic [1:0] ch, input logic [4:0] len,
                       input logic st, input logic en, input logic [DW-1:0] dat,
                       input logic push, input logic last, input logic clr,
                       input logic [2:0] eset, input logic grant_nx,
                       input int reserve, input logic rel_all);
    logic pop;
    fmt_req    = req;
    fmt_chid   = ch;
    fmt_length = len;
    fmt_start  = st;
    fmt_end    = en;
    fmt_data   = dat;
    err_clr    = clr;
    if (rdy_zero_left > 0) begin
      out_ready = 1'b0;
      rdy_zero_left--;
    end else if (rdy_mode == 0) out_ready = 1'b0;
    else if (rdy_mode == 2)     out_ready = 1'b1;
    else                        out_ready = 1'($urandom_range(0, 1));
    pop = out_ready && (exp_q.size() != 0);
    @(posedge clk);
    if (pop) void'(exp_q.pop_front());
    if (push) begin
      exp_q.push_back({dat, ch, last});
      reserved--;
    end
    if (rel_all) reserved = 0;
    if (reserve > 0) reserved = reserve;
    err_m   = (err_m & ~{3{clr}}) | eset;
    grant_m = grant_nx;
    #1;
    check_outputs();
  endtask

  task automatic idle(input logic clr);
    cycle(1'b0, 2'd0, 5'd0, 1'b0, 1'b0, DW'($urandom), 1'b0, 1'b0, clr, 3'b000, 1'b0, 0, 1'b0);
  endtask

  // mode: 0 normal, 1 no start, 2 end at word e_idx, 3 end never,
  //       4 start again at word e_idx, 5 abandon burst at word e_idx
  task automatic send_pkt(input logic [1:0] ch, input logic [4:0] len, input int mode, input int e_idx);
    int   guard;
    logic ok, at_end, st, en, lst, rel;
    logic [2:0] eset;
    if (len == 5'd0) begin
      cycle(1'b1, ch, 5'd0, 1'b0, 1'b0, DW'($urandom), 1'b0, 1'b0,
            1'($urandom_range(0, 1)), 3'b100, 1'b0, 0, 1'b0);
      return;
    end
    guard = 0;
    forever begin
      gnt_en = rand_gnt_en ? ($urandom_range(0, 3) != 0) : 1'b1;
      ok = gnt_en && (credit_model() >= int'(len));
      if (ok) credit_at_grant = int'(credit);
      cycle(1'b1, ch, len, 1'b0, 1'b0, DW'($urandom), 1'b0, 1'b0, 1'b0, 3'b000,
            ok, ok ? int'(len) : 0, 1'b0);
      if (ok) break;
      guard++;
      if (guard > 400) begin
        check_eq("grant_timeout", 64'(guard), 64'(0));
        idle(1'b0);
        return;
      end
    end
    cycle(1'b0, ch, len, 1'b0, 1'b0, DW'($urandom), 1'b0, 1'b0, 1'b0, 3'b000, 1'b0, 0, 1'b0);
    if (mode == 1) begin
      cycle(1'b0, ch, len, 1'b0, 1'b0, DW'($urandom), 1'b0, 1'b0, 1'b0, 3'b001, 1'b0, 0, 1'b1);
      return;
    end
    for (int i = 0; i < int'(len); i++) begin
      if (mode == 5 && i == e_idx) return;
      at_end = (i == int'(len) - 1);
      st     = (i == 0) || (mode == 4 && i == e_idx);
      en     = (mode == 2) ? (i == e_idx) : (mode == 3) ? 1'b0 : at_end;
      lst    = at_end || en;
      eset   = 3'b000;
      if (en != at_end)  eset[1] = 1'b1;
      if (i > 0 && st)   eset[1] = 1'b1;
      rel    = en && !at_end;
      cycle(1'b0, ch, len, st, en, DW'($urandom), 1'b1, lst, 1'b0, eset, 1'b0, 0, rel);
      if (lst) break;
    end
  endtask

  task automatic drain();
    int g;
    rdy_mode = 2;
    g = 0;
    while (exp_q.size() != 0 && g < 100) begin
      idle(1'b0);
      g++;
    end
    check_eq("drain_done", 64'(exp_q.size()), 64'(0));
  endtask

  task automatic do_reset();
    rstn      = 1'b0;
    fmt_req   = 1'b0;
    fmt_start = 1'b0;
    fmt_end   = 1'b0;
    err_clr   = 1'b0;
    out_ready = 1'b0;
    exp_q.delete();
    reserved = 0;
    err_m    = 3'b000;
    grant_m  = 1'b0;
    #1;
    check_outputs();
    @(posedge clk);
    #1;
    rstn = 1'b1;
  endtask

  initial begin
    logic [4:0] len;
    int         m, e;
    rstn = 1'b0; gnt_en = 1'b1; fmt_req = 1'b0; fmt_chid = '0; fmt_length = '0;
    fmt_start = 1'b0; fmt_end = 1'b0; fmt_data = '0; out_ready = 1'b0; err_clr = 1'b0;
    reserved = 0; err_m = 3'b000; grant_m = 1'b0;
    rdy_mode = 1; rdy_zero_left = 0; rand_gnt_en = 1'b0; credit_at_grant = 0;

    repeat (3) @(posedge clk);
    #1;
    check_outputs();
    check_eq("rst_credit", 64'(credit), 64'(32));
    rstn = 1'b1;

    // Plain 4-word packet on channel 2
    rdy_mode = 2;
    send_pkt(2'd2, 5'd4, 0, 0);
    drain();
    check_eq("t1_err", 64'(err), 64'(0));

    // Credit exhaustion: 31 words held, then a 4-word request waits for pops
    rdy_mode = 0;
    send_pkt(2'd0, 5'd31, 0, 0);
    check_eq("t2_credit_low", 64'(credit), 64'(1));
    rdy_zero_left = 4;
    rdy_mode      = 2;
    send_pkt(2'd1, 5'd4, 0, 0);
    check_eq("t2_credit_at_grant", 64'(credit_at_grant), 64'(4));
    drain();

    // Single-word packet with start and end together
    rdy_mode = 0;
    send_pkt(2'd3, 5'd1, 0, 0);
    check_eq("t3_credit", 64'(credit), 64'(31));
    check_eq("t3_last", 64'(out_last), 64'(1));
    rdy_mode = 2;
    idle(1'b0);
    check_eq("t3_credit_pop", 64'(credit), 64'(32));

    // Missing start releases the reservation
    send_pkt(2'd0, 5'd5, 1, 0);
    check_eq("t4_err", 64'(err), 64'(3'b001));
    check_eq("t4_credit", 64'(credit), 64'(32));
    idle(1'b1);

    // Early end on word 3 of 6
    rdy_mode = 0;
    send_pkt(2'd1, 5'd6, 2, 2);
    check_eq("t5_err", 64'(err), 64'(3'b010));
    check_eq("t5_credit", 64'(credit), 64'(29));
    drain();
    check_eq("t5_credit_drained", 64'(credit), 64'(32));
    idle(1'b1);

    // Reset in the middle of an 8-word burst, then a clean 2-word packet
    rdy_mode = 0;
    send_pkt(2'd2, 5'd8, 5, 2);
    do_reset();
    check_eq("t6_grant", 64'(fmt_grant), 64'(0));
    check_eq("t6_valid", 64'(out_valid), 64'(0));
    check_eq("t6_credit", 64'(credit), 64'(32));
    rdy_mode = 2;
    send_pkt(2'd1, 5'd2, 0, 0);
    drain();
    check_eq("t6_err", 64'(err), 64'(0));

    // Zero length with a same-cycle clear: the new error survives
    send_pkt(2'd0, 5'd3, 1, 0);
    cycle(1'b1, 2'd0, 5'd0, 1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b1, 3'b100, 1'b0, 0, 1'b0);
    check_eq("zlen_clr_prio", 64'(err), 64'(3'b100));
    idle(1'b1);

    // Randomized traffic
    rand_gnt_en = 1'b1;
    rdy_mode    = 1;
    for (int p = 0; p < 200; p++) begin
      repeat ($urandom_range(0, 2)) idle(1'($urandom_range(0, 7) == 0));
      len = ($urandom_range(0, 19) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
      m   = $urandom_range(0, 5);
      e   = 0;
      case (m)
        2: m = 1;
        3: if (len >= 5'd2) begin m = 2; e = $urandom_range(0, int'(len) - 2); end else m = 0;
        4: m = 3;
        5: if (len >= 5'd2) begin m = 4; e = $urandom_range(1, int'(len) - 1); end else m = 0;
        default: m = 0;
      endcase
      send_pkt(2'($urandom_range(0, 3)), len, m, e);
    end
    rand_gnt_en = 1'b0;
    drain();
    check_eq("final_credit", 64'(credit), 64'(32));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
